// File: rtl/ice40_reset_seq.sv
`timescale 1ns/1ps
// ice40_reset_seq: sequences core -> cam -> run reset release after POR sync and filtered PLL lock.
// Latency: rst_s_n after SYNC_STAGES edges, then LOCK_FILTER / CAM_DLY / RUN_DLY cycle gaps.
// Backpressure: none; lock loss or soft_rst_req re-arms the sequence from LOCK.
// Ports: clk; resetn (async POR, active low); pll_lock (async); soft_rst_req (sync pulse);
//        core_resetn, cam_resetn, run_resetn, seq_done, seq_state[2:0] (all registered).
module ice40_reset_seq #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned LOCK_FILTER = 16,
  parameter int unsigned CAM_DLY     = 1000,
  parameter int unsigned RUN_DLY     = 256,
  parameter int unsigned CNT_W       = 16
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       pll_lock,
  input  logic       soft_rst_req,
  output logic       core_resetn,
  output logic       cam_resetn,
  output logic       run_resetn,
  output logic       seq_done,
  output logic [2:0] seq_state
);

  typedef enum logic [2:0] {
    ST_RST  = 3'd0,
    ST_LOCK = 3'd1,
    ST_CAM  = 3'd2,
    ST_RUN  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_FILTER - 1);
  localparam logic [CNT_W-1:0] CAM_LAST  = CNT_W'(CAM_DLY - 1);
  localparam logic [CNT_W-1:0] RUN_LAST  = CNT_W'(RUN_DLY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  // ---------------------------------------------------------------------------
  // Reset synchroniser: async assert, deassert after SYNC_STAGES edges.
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] rst_sync_q;
  logic [SYNC_STAGES-1:0] rst_sync_d;
  logic                   rst_s_n;

  always_comb begin
    rst_sync_d = {rst_sync_q[SYNC_STAGES-2:0], 1'b1};
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rst_sync_q <= '0;
    end else begin
      rst_sync_q <= rst_sync_d;
    end
  end

  assign rst_s_n = rst_sync_q[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // PLL lock synchroniser. Cleared by raw resetn so a lock seen before the
  // reset synchroniser finishes is already stable when the FSM starts.
  // ---------------------------------------------------------------------------
  logic [1:0] lock_sync_q;
  logic [1:0] lock_sync_d;
  logic       lock_s;

  always_comb begin
    lock_sync_d = {lock_sync_q[0], pll_lock};
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lock_sync_q <= 2'b00;
    end else begin
      lock_sync_q <= lock_sync_d;
    end
  end

  assign lock_s = lock_sync_q[1];

  // ---------------------------------------------------------------------------
  // Sequencer FSM, delay counter and registered outputs, all on rst_s_n.
  // Raw resetn low clears rst_sync_q at once, which in turn clears these
  // flops, so outputs drop without waiting for a clock edge.
  // ---------------------------------------------------------------------------
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             core_q, core_d;
  logic             cam_q, cam_d;
  logic             run_q, run_d;
  logic             done_q, done_d;
  logic             abort;

  assign abort = soft_rst_req || !lock_s;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    core_d  = core_q;
    cam_d   = cam_q;
    run_d   = run_q;
    done_d  = done_q;

    case (state_q)
      ST_RST: begin
        state_d = ST_LOCK;
        cnt_d   = '0;
      end

      ST_LOCK: begin
        // Filter needs LOCK_FILTER consecutive lock_s cycles; a soft request
        // restarts the filter window.
        if (abort) begin
          cnt_d = '0;
        end else if (cnt_q == LOCK_LAST) begin
          state_d = ST_CAM;
          core_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      ST_CAM, ST_RUN, ST_DONE: begin
        // Abort is checked first so it wins over a delay expiring on the same edge.
        if (abort) begin
          state_d = ST_LOCK;
          cnt_d   = '0;
          core_d  = 1'b0;
          cam_d   = 1'b0;
          run_d   = 1'b0;
          done_d  = 1'b0;
        end else if (state_q == ST_CAM) begin
          if (cnt_q == CAM_LAST) begin
            state_d = ST_RUN;
            cam_d   = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end else if (state_q == ST_RUN) begin
          if (cnt_q == RUN_LAST) begin
            state_d = ST_DONE;
            run_d   = 1'b1;
            done_d  = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end else begin
          cnt_d = '0;
        end
      end

      default: begin
        state_d = ST_RST;
        cnt_d   = '0;
        core_d  = 1'b0;
        cam_d   = 1'b0;
        run_d   = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_s_n) begin
    if (!rst_s_n) begin
      state_q <= ST_RST;
      cnt_q   <= '0;
      core_q  <= 1'b0;
      cam_q   <= 1'b0;
      run_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      core_q  <= core_d;
      cam_q   <= cam_d;
      run_q   <= run_d;
      done_q  <= done_d;
    end
  end

  assign core_resetn = core_q;
  assign cam_resetn  = cam_q;
  assign run_resetn  = run_q;
  assign seq_done    = done_q;
  assign seq_state   = state_q;

endmodule
